// File: rtl/hamming_enc_arbiter.sv
// hamming_enc_arbiter: round-robin shared Hamming(15,11) encoder with a registered valid/ready output
module hamming_enc_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*11-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [14:0]            out_code,
    output logic [ID_W-1:0]        out_id,
    output logic [CNT_W-1:0]       cnt_out
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [14:0]      r_code;
    logic [ID_W-1:0]  r_id;
    logic [CNT_W-1:0] r_cnt;

    logic             w_hi_found;
    logic             w_lo_found;
    logic [ID_W-1:0]  w_hi;
    logic [ID_W-1:0]  w_lo;
    logic [ID_W-1:0]  w_winner;
    logic [10:0]      w_word;
    logic             w_can_load;
    logic             w_accept;
    logic             w_drain;

    // Even-parity Hamming(15,11); parity bits sit at positions 1,2,4,8 (indices 0,1,3,7)
    function automatic logic [14:0] enc(input logic [10:0] d);
        logic [14:0] c;
        c       = '0;
        c[2]    = d[0];
        c[4]    = d[1];
        c[5]    = d[2];
        c[6]    = d[3];
        c[14:8] = d[10:4];
        c[0]    = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
        c[1]    = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
        c[3]    = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
        c[7]    = ^c[14:8];
        return c;
    endfunction

    // Round-robin search: lowest valid index at or above ptr, else lowest valid index overall
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo_found = 1'b1;
                w_lo       = ID_W'(i);
                if (i >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi       = ID_W'(i);
                end
            end
        end
    end

    assign w_winner   = w_hi_found ? w_hi : w_lo;
    assign w_can_load = rst_n & en & ((r_state == EMPTY) | out_ready);
    assign w_accept   = w_lo_found & w_can_load;
    assign w_drain    = (r_state == FULL) & out_ready;

    // Select the winner's data word and raise its one-hot accept strobe
    always_comb begin
        w_word    = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_word       = req_data[11*i +: 11];
                req_ready[i] = w_accept;
            end
        end
    end

    // Output holding register occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Accept always fills; a drain without a concurrent accept empties
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)     w_state_nxt = FULL;
        else if (w_drain) w_state_nxt = EMPTY;
    end

    // Codeword, source id and round-robin pointer update on accept only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= '0;
            r_id   <= '0;
            r_ptr  <= '0;
        end else if (w_accept) begin
            r_code <= enc(w_word);
            r_id   <= w_winner;
            r_ptr  <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
        end
    end

    // Saturating count of delivered codewords
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_cnt <= '0;
        else if (w_drain && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end

    assign out_valid = (r_state == FULL);
    assign out_code  = r_code;
    assign out_id    = r_id;
    assign cnt_out   = r_cnt;
endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// tb_hamming_enc_arbiter: directed table-driven check of the shared Hamming encoder arbiter
module tb_hamming_enc_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [43:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [14:0] out_code;
    logic [1:0]  out_id;
    logic [3:0]  cnt_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  v;
        logic [43:0] d;
        logic        en;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [14:0] code;
        logic [1:0]  id;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl [13];

    hamming_enc_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_id(out_id), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic step(input string n, input logic [3:0] v, input logic [43:0] d, input logic e,
                        input logic ordy, input logic [3:0] rdy, input logic ov,
                        input logic [14:0] code, input logic [1:0] id, input logic [3:0] cnt);
        req_valid = v;
        req_data  = d;
        en        = e;
        out_ready = ordy;
        #3;
        chk({n, ".ready"}, 32'(req_ready), 32'(rdy));
        @(posedge clk);
        #1;
        chk({n, ".valid"}, 32'(out_valid), 32'(ov));
        chk({n, ".code"}, 32'(out_code), 32'(code));
        chk({n, ".id"}, 32'(out_id), 32'(id));
        chk({n, ".cnt"}, 32'(cnt_out), 32'(cnt));
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_data  = '0;
        en        = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.code", 32'(out_code), 0);
        chk("rst.id", 32'(out_id), 0);
        chk("rst.cnt", 32'(cnt_out), 0);
    endtask

    localparam logic [43:0] RR_DATA = {11'h008, 11'h004, 11'h002, 11'h001};

    initial begin
        logic [14:0] rr_code [4];
        rr_code = '{15'h0007, 15'h0019, 15'h002A, 15'h004B};

        tbl[0]  = '{4'b0001, {33'h0, 11'h001},              1, 1, 4'b0001, 1, 15'h0007, 2'd0, 4'd0};
        tbl[1]  = '{4'b0000, 44'h0,                         1, 1, 4'b0000, 0, 15'h0007, 2'd0, 4'd1};
        tbl[2]  = '{4'b0100, {11'h0, 11'h7FF, 22'h0},       1, 1, 4'b0100, 1, 15'h7FFF, 2'd2, 4'd1};
        tbl[3]  = '{4'b0100, {11'h0, 11'h400, 22'h0},       1, 1, 4'b0100, 1, 15'h408B, 2'd2, 4'd2};
        tbl[4]  = '{4'b0100, {11'h0, 11'h000, 22'h0},       1, 1, 4'b0100, 1, 15'h0000, 2'd2, 4'd3};
        tbl[5]  = '{4'b0010, {22'h0, 11'h002, 11'h0},       1, 1, 4'b0010, 1, 15'h0019, 2'd1, 4'd4};
        tbl[6]  = '{4'b1000, {11'h004, 33'h0},              1, 1, 4'b1000, 1, 15'h002A, 2'd3, 4'd5};
        tbl[7]  = '{4'b0001, {33'h0, 11'h008},              1, 1, 4'b0001, 1, 15'h004B, 2'd0, 4'd6};
        tbl[8]  = '{4'b0000, 44'h0,                         1, 1, 4'b0000, 0, 15'h004B, 2'd0, 4'd7};
        tbl[9]  = '{4'b0001, {33'h0, 11'h010},              1, 1, 4'b0001, 1, 15'h0181, 2'd0, 4'd7};
        tbl[10] = '{4'b0000, 44'h0,                         1, 0, 4'b0000, 1, 15'h0181, 2'd0, 4'd7};
        tbl[11] = '{4'b0011, {22'h0, 11'h7FF, 11'h7FF},     1, 0, 4'b0000, 1, 15'h0181, 2'd0, 4'd7};
        tbl[12] = '{4'b0000, 44'h0,                         1, 1, 4'b0000, 0, 15'h0181, 2'd0, 4'd8};

        do_reset();
        for (int i = 0; i < 13; i++)
            step($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].en, tbl[i].ordy,
                 tbl[i].rdy, tbl[i].ov, tbl[i].code, tbl[i].id, tbl[i].cnt);

        do_reset();
        for (int k = 0; k < 5; k++)
            step($sformatf("rr%0d", k), 4'b1111, RR_DATA, 1, 1, 4'(1 << (k % 4)), 1,
                 rr_code[k % 4], 2'(k % 4), 4'(k));
        for (int k = 0; k < 5; k++)
            step($sformatf("bp%0d", k), 4'b1111, RR_DATA, 1, 0, 4'b0000, 1, 15'h0007, 2'd0, 4'd4);
        step("bp_release", 4'b1111, RR_DATA, 1, 1, 4'b0010, 1, 15'h0019, 2'd1, 4'd5);

        step("en_off0", 4'b1111, RR_DATA, 0, 1, 4'b0000, 0, 15'h0019, 2'd1, 4'd6);
        step("en_off1", 4'b1111, RR_DATA, 0, 1, 4'b0000, 0, 15'h0019, 2'd1, 4'd6);
        step("en_on",   4'b1111, RR_DATA, 1, 1, 4'b0100, 1, 15'h002A, 2'd2, 4'd6);
        step("pre_rst", 4'b1111, RR_DATA, 1, 1, 4'b1000, 1, 15'h004B, 2'd3, 4'd7);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async.valid", 32'(out_valid), 0);
        chk("async.cnt", 32'(cnt_out), 0);
        chk("async.ready", 32'(req_ready), 0);
        chk("async.code", 32'(out_code), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst", 4'b1111, RR_DATA, 1, 1, 4'b0001, 1, 15'h0007, 2'd0, 4'd0);

        do_reset();
        for (int k = 0; k < 20; k++)
            step($sformatf("sat%0d", k), 4'b0001, {33'h0, 11'h001}, 1, 1, 4'b0001, 1,
                 15'h0007, 2'd0, 4'((k > 15) ? 15 : k));
        step("sat_hold0", 4'b0000, 44'h0, 1, 1, 4'b0000, 0, 15'h0007, 2'd0, 4'd15);
        step("sat_hold1", 4'b0001, {33'h0, 11'h001}, 1, 1, 4'b0001, 1, 15'h0007, 2'd0, 4'd15);
        step("sat_hold2", 4'b0000, 44'h0, 1, 1, 4'b0000, 0, 15'h0007, 2'd0, 4'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hamming_enc_arbiter.md
Name: hamming_enc_arbiter

Overview:
- Shares one Hamming(15,11) even-parity encoder among NUM_REQ requesters.
- Each requester presents an 11-bit word with a valid/ready handshake. A round-robin arbiter grants one requester per accepted transfer.
- The encoded 15-bit codeword, tagged with the source requester ID, is registered and presented on a valid/ready output port toward the transmit/storage path.
- A saturating counter reports the number of codewords delivered.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of out_id; must satisfy 2**ID_W >= NUM_REQ.
- CNT_W, 16, width of the delivered-codeword counter.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  1 = new grants allowed; 0 = no new grants, held output still drains
- req_valid  input  NUM_REQ  bit i = requester i has a word
- req_data  input  NUM_REQ*11  requester i word at [11*i+10 : 11*i]
- req_ready  output  NUM_REQ  one-hot (or zero) accept strobe per requester
- out_valid  output  1  out_code/out_id valid
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_code  output  15  encoded codeword
- out_id  output  ID_W  index of the requester that sourced out_code
- cnt_out  output  CNT_W  delivered codewords, saturates at all-ones

Behaviour:
- Encoding (codeword bit k = position k+1), d = 11-bit data:
  - code[2]=d0, code[4]=d1, code[5]=d2, code[6]=d3, code[14:8]=d10..d4.
  - code[0] = ^code{2,4,6,8,10,12,14}.
  - code[1] = ^code{2,5,6,9,10,13,14}.
  - code[3] = ^code{4,5,6,11,12,13,14}.
  - code[7] = ^code{8..14}.
- Output register FSM, states EMPTY (out_valid=0) and FULL (out_valid=1).
  - can_load = en & (EMPTY | out_ready).
- Arbitration (combinational):
  - Search req_valid starting at index ptr and wrapping modulo NUM_REQ.
  - The first set bit wins.
  - If can_load, req_ready[winner]=1; all other req_ready bits are 0.
  - req_ready is 0 when no request is pending or can_load=0.
  - req_ready may depend on req_valid and out_ready; there is no dependency path from req_ready to valid.
- Accept edge (any req_valid & req_ready):
  - out_code <= enc(req_data of winner), out_id <= winner.
  - State -> FULL.
  - ptr <= (winner+1) mod NUM_REQ.
- Latency: exactly 1 cycle from the accept edge to out_valid. Throughput is 1 word/cycle when out_ready is held high.
- Drain edge (FULL & out_ready) with no accept in the same cycle: state -> EMPTY. out_code/out_id hold their last values.
- Simultaneous drain and accept: the new word replaces the old one with no bubble, and state stays FULL.
- FULL & !out_ready: out_code/out_id/out_valid must stay stable; all req_ready are 0.
- en=0: no accepts. A FULL register still drains on out_ready. ptr is unchanged.
- Counter: cnt_out increments on every drain edge (out_valid & out_ready). It holds at 2**CNT_W-1 and does not wrap.
- ptr changes only on accept. A requester that drops valid without being granted loses nothing.
- Reset (async assert, any time, including while FULL):
  - out_valid=0, state EMPTY, out_code=0, out_id=0, ptr=0, cnt_out=0.
  - req_ready=0 while rst_n=0.
  - Any held codeword is discarded.
- Release of rst_n is synchronised externally. The first grant is possible in the first clock edge with rst_n=1.

Test Plan:
1. Single requester 0, data 11'h001, en=1, out_ready=1 -> req_ready[0]=1 that cycle. Next cycle out_valid=1, out_code=15'h0007, out_id=0. cnt_out=1 after drain.
2. Encode corners, via requester 2:
   - 11'h7FF -> out_code=15'h7FFF, out_id=2.
   - 11'h400 -> out_code=15'h408B.
   - 11'h000 -> out_code=15'h0000.
3. All 4 requesters valid continuously, out_ready=1, ptr=0 after reset -> grants 0,1,2,3,0,... on consecutive cycles. out_valid held high and out_id sequence 0,1,2,3,0.
4. Backpressure: load a word, then hold out_ready=0 for 5 cycles with req_valid=4'b1111 -> out_code/out_id stable and req_ready=0 throughout. On out_ready=1 the held word drains and a new word loads the same cycle.
5. en=0 with all requesters valid -> no req_ready. A previously FULL register drains once, then out_valid=0. Re-enabling resumes from the saved ptr.
6. Assert rst_n=0 mid-burst while FULL with cnt_out=7 -> out_valid=0, cnt_out=0 and req_ready=0 immediately (asynchronous). After release, requester 0 is granted first.
7. Counter saturation (CNT_W=4): 20 drains -> cnt_out=15 and holds at 15.
